// File: rtl/regfile_pkg.sv
// Shared constants and clear-FSM state type for the register file bank.
package regfile_pkg;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Bulk-clear sequencer: walks a pointer over registers 1..31, one per cycle.
module regfile_clear_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output state_t            state
);

    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= FIRST_ADDR;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Register 0 is hardwired to zero, so the walk starts at 1 and never wraps to 0.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        busy       = 1'b0;
        clr_en     = 1'b0;
        clr_addr   = ptr;
        case (state)
            IDLE: begin
                ptr_next = FIRST_ADDR;
                if (clr_req) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_en = 1'b1;
                if (ptr == LAST_ADDR) begin
                    state_next = IDLE;
                    ptr_next   = FIRST_ADDR;
                end else begin
                    ptr_next = ptr + ADDR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = FIRST_ADDR;
            end
        endcase
    end

endmodule

// File: rtl/regfile_bank.sv
// 32-entry register bank with a valid/ready write port, zero register 0 and
// a multi-cycle bulk clear that stalls writes while it runs.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int WIDTH = regfile_pkg::WIDTH,
    parameter int DEPTH = regfile_pkg::DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // Handshake: a write is taken at a rising edge where wr_valid && wr_ready;
    // upstream must hold wr_valid/wr_addr/wr_data stable until then.
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [regfile_pkg::ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH-1:0]                  wr_data,
    input  logic                              clr_req,
    output logic                              busy,
    output logic [WIDTH-1:0]                  q0,  q1,  q2,  q3,  q4,  q5,  q6,  q7,
    output logic [WIDTH-1:0]                  q8,  q9,  q10, q11, q12, q13, q14, q15,
    output logic [WIDTH-1:0]                  q16, q17, q18, q19, q20, q21, q22, q23,
    output logic [WIDTH-1:0]                  q24, q25, q26, q27, q28, q29, q30, q31
);

    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    state_t            ctrl_state;
    logic              wr_en;
    logic [WIDTH-1:0]  rq [32];

    regfile_clear_ctrl u_clear_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .state    (ctrl_state)
    );

    assign wr_ready = (ctrl_state == IDLE);
    assign wr_en    = wr_valid && wr_ready;

    assign rq[0] = '0;

    // Write and clear are mutually exclusive because wr_ready drops in CLEAR.
    for (genvar i = 1; i < 32; i++) begin : g_reg
        if (i < DEPTH) begin : g_store
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rq[i] <= '0;
                end else if (clr_en && clr_addr == ADDR_W'(i)) begin
                    rq[i] <= '0;
                end else if (wr_en && wr_addr == ADDR_W'(i)) begin
                    rq[i] <= wr_data;
                end
            end
        end else begin : g_absent
            assign rq[i] = '0;
        end
    end

    assign q0  = rq[0];  assign q1  = rq[1];  assign q2  = rq[2];  assign q3  = rq[3];
    assign q4  = rq[4];  assign q5  = rq[5];  assign q6  = rq[6];  assign q7  = rq[7];
    assign q8  = rq[8];  assign q9  = rq[9];  assign q10 = rq[10]; assign q11 = rq[11];
    assign q12 = rq[12]; assign q13 = rq[13]; assign q14 = rq[14]; assign q15 = rq[15];
    assign q16 = rq[16]; assign q17 = rq[17]; assign q18 = rq[18]; assign q19 = rq[19];
    assign q20 = rq[20]; assign q21 = rq[21]; assign q22 = rq[22]; assign q23 = rq[23];
    assign q24 = rq[24]; assign q25 = rq[25]; assign q26 = rq[26]; assign q27 = rq[27];
    assign q28 = rq[28]; assign q29 = rq[29]; assign q30 = rq[30]; assign q31 = rq[31];

endmodule

// File: tb/tb_regfile_bank.sv
// Directed self-checking bench for regfile_bank.
module tb_regfile_bank;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr_req;
    logic        busy;
    logic [31:0] q0,  q1,  q2,  q3,  q4,  q5,  q6,  q7;
    logic [31:0] q8,  q9,  q10, q11, q12, q13, q14, q15;
    logic [31:0] q16, q17, q18, q19, q20, q21, q22, q23;
    logic [31:0] q24, q25, q26, q27, q28, q29, q30, q31;
    logic [31:0] qv [32];

    int n_cmp = 0;
    int n_err = 0;

    regfile_bank #(.WIDTH(32), .DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy),
        .q0(q0),   .q1(q1),   .q2(q2),   .q3(q3),   .q4(q4),   .q5(q5),   .q6(q6),   .q7(q7),
        .q8(q8),   .q9(q9),   .q10(q10), .q11(q11), .q12(q12), .q13(q13), .q14(q14), .q15(q15),
        .q16(q16), .q17(q17), .q18(q18), .q19(q19), .q20(q20), .q21(q21), .q22(q22), .q23(q23),
        .q24(q24), .q25(q25), .q26(q26), .q27(q27), .q28(q28), .q29(q29), .q30(q30), .q31(q31)
    );

    assign qv[0]  = q0;  assign qv[1]  = q1;  assign qv[2]  = q2;  assign qv[3]  = q3;
    assign qv[4]  = q4;  assign qv[5]  = q5;  assign qv[6]  = q6;  assign qv[7]  = q7;
    assign qv[8]  = q8;  assign qv[9]  = q9;  assign qv[10] = q10; assign qv[11] = q11;
    assign qv[12] = q12; assign qv[13] = q13; assign qv[14] = q14; assign qv[15] = q15;
    assign qv[16] = q16; assign qv[17] = q17; assign qv[18] = q18; assign qv[19] = q19;
    assign qv[20] = q20; assign qv[21] = q21; assign qv[22] = q22; assign qv[23] = q23;
    assign qv[24] = q24; assign qv[25] = q25; assign qv[26] = q26; assign qv[27] = q27;
    assign qv[28] = q28; assign qv[29] = q29; assign qv[30] = q30; assign qv[31] = q31;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] exp [32]);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s_q%0d", tag, i), qv[i], exp[i]);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic fill_all(input logic [31:0] base);
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), base + 32'(i));
        end
    endtask

    logic [31:0] exp_q [32];
    int          cyc;

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        clr_req  = 1'b0;
        for (int i = 0; i < 32; i++) exp_q[i] = '0;

        // reset state
        #23;
        check_all("reset", exp_q);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr_ready", 32'(wr_ready), 32'd1);

        // first write accepted at the first edge after release
        @(negedge clk);
        rst_n    = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = 32'h0000_0005;
        tick();
        wr_valid = 1'b0;
        check("wr5_q5", q5, 32'h0000_0005);
        write_reg(5'd31, 32'h0000_001F);
        exp_q[5]  = 32'h0000_0005;
        exp_q[31] = 32'h0000_001F;
        check_all("wr31", exp_q);

        // writes to address 0 handshake but are dropped
        wr_valid = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 32'hDEAD_BEEF;
        check("wr0_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        check("wr0_q0", q0, 32'h0);

        // full clear with clr_req held for the first few clear cycles
        fill_all(32'h1000_0000);
        for (int i = 1; i < 32; i++) exp_q[i] = 32'h1000_0000 + 32'(i);
        check_all("fill", exp_q);
        clr_req = 1'b1;
        tick();
        check("clr_start_busy", 32'(busy), 32'd1);
        check("clr_start_ready", 32'(wr_ready), 32'd0);
        check("clr_start_q1", q1, 32'h1000_0001);
        for (int k = 1; k <= 31; k++) begin
            if (k == 4) clr_req = 1'b0;
            check($sformatf("clr_busy_pre%0d", k), 32'(busy), 32'd1);
            tick();
            exp_q[k] = '0;
            check($sformatf("clr_k%0d_q%0d", k, k), qv[k], 32'h0);
            if (k < 31) check($sformatf("clr_k%0d_q%0d", k, k + 1), qv[k + 1], 32'h1000_0000 + 32'(k + 1));
        end
        check("clr_end_busy", 32'(busy), 32'd0);
        check("clr_end_ready", 32'(wr_ready), 32'd1);
        check_all("clr_end", exp_q);
        tick();
        check("clr_no_restart", 32'(busy), 32'd0);

        // simultaneous write to 7 and clear request
        wr_valid = 1'b1;
        wr_addr  = 5'd7;
        wr_data  = 32'h0000_0077;
        clr_req  = 1'b1;
        tick();
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        check("sim_q7", q7, 32'h0000_0077);
        check("sim_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("sim_k%0d_q7", k), q7, 32'h0000_0077);
        end
        tick();
        check("sim_k7_q7", q7, 32'h0);
        cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
        check("sim_rest_cycles", 32'(cyc), 32'd24);

        // write held through a clear, accepted on the first idle edge
        write_reg(5'd3, 32'h1234_5678);
        clr_req = 1'b1;
        tick();
        clr_req  = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = 32'hA5A5_A5A5;
        cyc = 0;
        while (busy && cyc < 40) begin
            check($sformatf("hold_ready_c%0d", cyc), 32'(wr_ready), 32'd0);
            tick();
            cyc++;
        end
        check("hold_cycles", 32'(cyc), 32'd31);
        check("hold_q3_pre", q3, 32'h0);
        check("hold_ready_idle", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        check("hold_q3", q3, 32'hA5A5_A5A5);

        // asynchronous reset mid-clear, then a fresh full-length clear
        fill_all(32'h2000_0000);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("mid_q10", q10, 32'h0);
        check("mid_q11", q11, 32'h2000_000B);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) exp_q[i] = '0;
        check_all("arst", exp_q);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_busy", 32'(busy), 32'd0);
        write_reg(5'd20, 32'h0000_0020);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
        check("post_rst_cycles", 32'(cyc), 32'd31);
        check("post_rst_q20", q20, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
